imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
Parametrised successor to the single-cycle immediate generator. It is a registered pipeline stage that decodes every RV32I immediate format and sign-extends to XLEN. It carries a valid/ready handshake with a 2-entry skid buffer and supports a synchronous flush. It sits between instruction fetch and register-read, feeding the ALU operand mux and the branch unit.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills bits XLEN-1..32.
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single output register with in_ready = out_ready | ~out_valid.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline kill; drops all held entries.
in_valid  in  1  instruction present.
in_ready  out  1  stage can accept.
in_instr  in  32  raw instruction word.
out_valid  out  1  decoded entry present.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  format code (see package).
out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11.

Behaviour:
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- out_* is stable while out_valid & ~out_ready. out_valid never drops without a transfer, except on flush or reset.
- Format selection on in_instr[6:0]:
  - 0000011 (load), 1100111 (JALR), 0010011 (OP-IMM, except shifts): fmt I, imm = sext(instr[31:20]).
  - OP-IMM with funct3 = 001 or 101: fmt SH, imm = zext(instr[24:20]). instr[30] is not part of the immediate.
  - 0100011: fmt S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Bit 0 is always 0.
  - 0110111 / 0010111: fmt U, imm = sext({instr[31:12], 12'b0}). The upper bits are sign-extended for XLEN = 64.
  - 1101111: fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 1110011: fmt Z, imm = zext(instr[19:15]).
  - 0110011 (R-type): fmt NONE, imm 0, illegal 0.
  - Any other opcode, or instr[1:0] != 11: fmt NONE, imm 0, illegal 1. The entry is still forwarded with out_valid.
- Skid buffer (SKID = 1):
  - States EMPTY, ONE, FULL.
  - in_ready is registered and equals 1 in EMPTY and ONE, 0 in FULL.
  - EMPTY → ONE on input transfer.
  - ONE → ONE on simultaneous input and output transfer.
  - ONE → FULL on input transfer without output transfer.
  - ONE → EMPTY on output transfer only.
  - FULL → ONE on output transfer.
  - Order is strictly FIFO.
- Reset (synchronous; the reset-high cycle itself has in_ready = 0):
  - out_valid = 0, out_imm = 0, out_fmt = NONE, out_illegal = 0, state EMPTY.
  - in_ready = 1 on the first cycle after reset deasserts.
- Flush:
  - Next cycle: state EMPTY, out_valid = 0, out_imm/fmt/illegal zeroed.
  - Any input presented in the flush cycle is discarded, even if in_valid & in_ready.
  - Reset has priority over flush.
- Reset or flush mid-stall: held entries are lost; no partial output.

Decomposition:
- Package imm_pkg:
  - opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_REG.
  - fmt codes: NONE = 0, I = 1, S = 2, B = 3, U = 4, J = 5, Z = 6, SH = 7.
- Sub-module imm_extract: purely combinational instr → {imm, fmt, illegal}, parametrised by XLEN.
- Top-level content: skid buffer, FSM and flush logic.

Test Plan:
- Load and store: 0xFFC12083 (lw x1,-4(x2)) → fmt I, imm 0xFFFFFFFC. 0xFE112E23 (sw x1,-4(x2)) → fmt S, imm 0xFFFFFFFC, out_valid 1 cycle after accept.
- Branch, upper and jump: 0xFE000CE3 (beq -8) → fmt B, imm 0xFFFFFFF8. 0x123450B7 (lui) → fmt U, imm 0x12345000. 0x0010006F (jal +2048) → fmt J, imm 0x00000800.
- Shift and illegal: 0x00509093 (slli x1,x1,5) → fmt SH, imm 5. 0x0000007F → fmt NONE, illegal 1, imm 0. 0x00000000 → illegal 1.
- Backpressure: out_ready = 0 while 3 back-to-back valids are offered.
  - in_ready falls after the 2nd accept; the 3rd is held off.
  - On out_ready = 1, outputs appear in order with no loss or duplication.
- Flush and reset: flush while FULL with in_valid = 1 → next cycle out_valid 0, state EMPTY, flushed-cycle input never emerges. Reset asserted mid-stall → same, and in_ready = 1 after release.
- XLEN = 64: 0xFFC12083 → 0xFFFFFFFFFFFFFFFC. 0x800000B7 (lui 0x80000) → 0xFFFFFFFF80000000. SKID = 0 build passes the same stream with ordering preserved.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode map, format codes and sign-extension helper for the
// RV32I immediate decode stage.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_SH   = 3'd7
    } fmt_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I immediate extractor: one instruction word in,
// sign/zero-extended immediate, format code and illegal flag out.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_JALR: begin
                fmt   = FMT_I;
                imm32 = sext12(instr[31:20]);
            end
            OP_IMM: begin
                // Shift amounts are unsigned; instr[30] selects SRA and is not immediate data.
                if (instr[14:12] == F3_SLL || instr[14:12] == F3_SRX) begin
                    fmt   = FMT_SH;
                    imm32 = {27'b0, instr[24:20]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = sext12(instr[31:20]);
                end
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = sext12({instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                fmt   = FMT_Z;
                imm32 = {27'b0, instr[19:15]};
            end
            OP_REG: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Zero-extended formats have bit 31 clear, so one sign fill serves all.
    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm = imm32[XLEN-1:0];
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with valid/ready handshake,
// optional 2-entry skid buffer and synchronous flush.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    entry_t          dec;
    entry_t          head_q;
    entry_t          skid_q;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       in_ready_q;
    logic       accept;
    logic       pop;
    logic       load_head;
    logic       load_skid;
    logic       head_from_skid;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    // Without the skid buffer the stage degenerates to a single register that
    // never reaches FULL, because in_ready already requires room downstream.
    assign in_ready  = ~reset & ((SKID != 0) ? in_ready_q : (out_ready | ~out_valid));
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (load_head) begin
                head_q <= dec;
            end else if (head_from_skid) begin
                head_q <= skid_q;
            end
        end
    end

    // NOTE: the skid slot is data-only and not reset; state_q alone says whether it holds anything.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= dec;
        end
    end

    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: a 32-bit skid-buffered stage and a 64-bit single-register
// stage share one stimulus stream and are each tracked by a FIFO model.
module tb_imm_decode_stage;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NVEC = 15;

    vec_t vecs [NVEC] = '{
        '{32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0},
        '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0},
        '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0},
        '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0},
        '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0},
        '{32'h00509093, 64'h0000_0000_0000_0005, 3'd7, 1'b0},
        '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd0, 1'b1},
        '{32'h00000000, 64'h0000_0000_0000_0000, 3'd0, 1'b1},
        '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0},
        '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b0},
        '{32'h000FD073, 64'h0000_0000_0000_001F, 3'd6, 1'b0},
        '{32'h40F0D093, 64'h0000_0000_0000_000F, 3'd7, 1'b0},
        '{32'h00408067, 64'h0000_0000_0000_0004, 3'd1, 1'b0},
        '{32'h00000010, 64'h0000_0000_0000_0000, 3'd0, 1'b1},
        '{32'hFFFFF097, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0}
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    exp_t mfifo [2][4];
    int   mhead [2] = '{0, 0};
    int   mcount [2] = '{0, 0};
    bit   mzero [2] = '{1'b1, 1'b1};

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID(0)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Immediate value computed arithmetically from the ISA field definitions.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t   e;
        longint s;
        longint v;
        s = longint'($signed(ins));
        v = 0;
        e = '0;
        case (ins[6:0])
            7'h03, 7'h67: begin e.fmt = 3'd1; v = s >>> 20; end
            7'h13: begin
                if (ins[13:12] == 2'b01) begin e.fmt = 3'd7; v = longint'(ins[24:20]); end
                else begin e.fmt = 3'd1; v = s >>> 20; end
            end
            7'h23: begin e.fmt = 3'd2; v = (s >>> 25) * 32 + longint'(ins[11:7]); end
            7'h63: begin
                e.fmt = 3'd3;
                v = (ins[31] ? -4096 : 0) + (longint'(ins[7]) << 11)
                    + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = (s >>> 12) * 4096; end
            7'h6F: begin
                e.fmt = 3'd5;
                v = (ins[31] ? -1048576 : 0) + (longint'(ins[19:12]) << 12)
                    + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
            end
            7'h73: begin e.fmt = 3'd6; v = longint'(ins[19:15]); end
            7'h33: begin e.fmt = 3'd0; end
            default: begin e.ill = 1'b1; end
        endcase
        e.imm = v;
        return e;
    endfunction

    // Compares one DUT against its FIFO model, then applies the handshake of the coming edge.
    task automatic model_step(input int k, input bit skid, input bit wide, input logic rdy,
                              input logic vld, input logic [63:0] imm, input logic [2:0] fmt,
                              input logic ill);
        bit          mrdy;
        exp_t        h;
        logic [63:0] mask;
        string       p;
        p    = (k == 0) ? "a" : "b";
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mrdy = !reset && (skid ? (mcount[k] < 2) : (out_ready || mcount[k] == 0));
        check({p, ".in_ready"}, 64'(rdy), 64'(mrdy));
        check({p, ".out_valid"}, 64'(vld), 64'(mcount[k] > 0));
        if (mcount[k] > 0) begin
            h = mfifo[k][mhead[k]];
            check({p, ".out_imm"}, imm & mask, h.imm & mask);
            check({p, ".out_fmt"}, 64'(fmt), 64'(h.fmt));
            check({p, ".out_illegal"}, 64'(ill), 64'(h.ill));
        end else if (mzero[k]) begin
            check({p, ".zero_imm"}, imm, 64'd0);
            check({p, ".zero_fmt"}, 64'(fmt), 64'd0);
            check({p, ".zero_ill"}, 64'(ill), 64'd0);
        end
        if (reset || flush) begin
            mcount[k] = 0;
            mhead[k]  = 0;
            mzero[k]  = 1'b1;
        end else begin
            if (mcount[k] > 0 && out_ready) begin
                mhead[k] = (mhead[k] + 1) % 4;
                mcount[k]--;
            end
            if (in_valid && mrdy) begin
                mfifo[k][(mhead[k] + mcount[k]) % 4] = model_decode(in_instr);
                mcount[k]++;
                mzero[k] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_step(0, 1'b1, 1'b0, a_in_ready, a_out_valid, 64'(a_out_imm), a_out_fmt, a_out_illegal);
            model_step(1, 1'b0, 1'b1, b_in_ready, b_out_valid, b_out_imm, b_out_fmt, b_out_illegal);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_two(input logic [31:0] i1, input logic [31:0] i2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = i1;
        step();
        in_instr  = i2;
        step();
    endtask

    initial begin
        exp_t e;

        for (int i = 0; i < NVEC; i++) begin
            e = model_decode(vecs[i].ins);
            check($sformatf("model_imm[%0d]", i), e.imm, vecs[i].imm);
            check($sformatf("model_fmt[%0d]", i), 64'(e.fmt), 64'(vecs[i].fmt));
            check($sformatf("model_ill[%0d]", i), 64'(e.ill), 64'(vecs[i].ill));
        end

        step();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(a_in_ready), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_a_ready", 64'(a_in_ready), 64'd1);
        check("post_reset_b_ready", 64'(b_in_ready), 64'd1);
        check("post_reset_valid", 64'(a_out_valid), 64'd0);
        check("post_reset_fmt", 64'(a_out_fmt), 64'd0);

        // Directed decode: one instruction at a time, consumed immediately.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            step();
            in_valid = 1'b1;
            in_instr = vecs[i].ins;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("lat1_valid[%0d]", i), 64'(a_out_valid), 64'd1);
            check($sformatf("a_imm[%0d]", i), 64'(a_out_imm), vecs[i].imm & 64'h0000_0000_FFFF_FFFF);
            check($sformatf("a_fmt[%0d]", i), 64'(a_out_fmt), 64'(vecs[i].fmt));
            check($sformatf("a_ill[%0d]", i), 64'(a_out_illegal), 64'(vecs[i].ill));
            check($sformatf("b_imm[%0d]", i), b_out_imm, vecs[i].imm);
        end
        step();

        // Backpressure: three back-to-back offers with out_ready low.
        fill_two(vecs[0].ins, vecs[3].ins);
        in_instr = vecs[4].ins;
        @(negedge clk);
        check("bp_a_ready_low", 64'(a_in_ready), 64'd0);
        check("bp_b_ready_low", 64'(b_in_ready), 64'd0);
        step();
        @(negedge clk);
        check("bp_held_ready", 64'(a_in_ready), 64'd0);
        check("bp_held_imm", 64'(a_out_imm), 64'hFFFF_FFFC);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_second_imm", 64'(a_out_imm), 64'h1234_5000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third_imm", 64'(a_out_imm), 64'h0000_0800);
        check("bp_third_fmt", 64'(a_out_fmt), 64'd5);
        step();
        @(negedge clk);
        check("bp_drained", 64'(a_out_valid), 64'd0);

        // Flush while FULL with an input offered.
        step();
        fill_two(vecs[1].ins, vecs[2].ins);
        flush    = 1'b1;
        in_instr = vecs[5].ins;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(a_out_valid), 64'd0);
        check("flush_ready", 64'(a_in_ready), 64'd1);
        check("flush_imm", 64'(a_out_imm), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("flush_nothing_out", 64'(a_out_valid), 64'd0);

        // Flush while empty: the accepted-looking input must still be dropped.
        step();
        in_valid = 1'b1;
        in_instr = vecs[3].ins;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_empty_a", 64'(a_out_valid), 64'd0);
        check("flush_empty_b", 64'(b_out_valid), 64'd0);

        // Reset in the middle of a stall.
        step();
        fill_two(vecs[8].ins, vecs[10].ins);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("rst_stall_ready", 64'(a_in_ready), 64'd0);
        check("rst_stall_valid", 64'(a_out_valid), 64'd0);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_release_a", 64'(a_in_ready), 64'd1);
        check("rst_release_b", 64'(b_in_ready), 64'd1);
        check("rst_release_valid", 64'(b_out_valid), 64'd0);

        // Mixed traffic with random stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_instr  = vecs[$urandom_range(0, NVEC - 1)].ins;
        end
        step();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("final_drained_a", 64'(a_out_valid), 64'd0);
        check("final_drained_b", 64'(b_out_valid), 64'd0);
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
